cbs_frame_buffer: RTL and testbench

- Store-and-forward byte-wide Ethernet frame FIFO that sits directly downstream of the CBS-path frame dropper.
- Supplies the almost_full flag that drives the dropper's drop decision.
- Releases only complete, error-free frames to the CBS shaper/egress, so downstream never sees a partial or errored frame.
- Never backpressures upstream: an overflow mid-frame discards that whole frame.

---
 rtl/cbs_pkg.sv | 17 +
 rtl/cbs_frame_buffer_ram.sv | 31 +++
 rtl/cbs_frame_buffer.sv | 179 +++++++++++++++++
 tb/tb_cbs_frame_buffer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbs_pkg.sv
// Shared constants for the CBS egress path: AXIS byte width, maximum Ethernet
// frame length and the default frame-buffer geometry.
package cbs_pkg;

  localparam int AXIS_DATA_W        = 8;
  localparam int MAX_FRAME_LEN      = 1522;
  localparam int DEFAULT_ADDR_WIDTH = 11;

  // Buffer word is {tlast, data}
  localparam int RAM_WORD_W = AXIS_DATA_W + 1;

  typedef enum logic {
    WR_ACCEPT  = 1'b0,
    WR_DISCARD = 1'b1
  } wr_state_t;

endpackage

// File: rtl/cbs_frame_buffer_ram.sv
// Simple dual-port frame storage: one write port, one read port with a
// registered output that holds its value while rd_en_i is low.
module cbs_frame_buffer_ram
  import cbs_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [RAM_WORD_W-1:0] wr_word_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [RAM_WORD_W-1:0] rd_word_o
);

  logic [RAM_WORD_W-1:0] mem_q [2**ADDR_WIDTH];
  logic [RAM_WORD_W-1:0] rd_word_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_word_i;
    end
    if (rd_en_i) begin
      rd_word_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_word_o = rd_word_q;

endmodule

// File: rtl/cbs_frame_buffer.sv
// Store-and-forward byte FIFO behind the CBS dropper: only complete, error-free
// frames are released downstream, and upstream is never backpressured.
//   state      | meaning
//   WR_ACCEPT  | storing beats of the current frame at wr_spec
//   WR_DISCARD | buffer filled mid-frame; dropping beats up to tlast
module cbs_frame_buffer
  import cbs_pkg::*;
#(
  parameter int ADDR_WIDTH         = DEFAULT_ADDR_WIDTH,
  parameter int ALMOST_FULL_MARGIN = MAX_FRAME_LEN
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [AXIS_DATA_W-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tuser,
  output logic [AXIS_DATA_W-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  output logic                   almost_full,
  output logic [ADDR_WIDTH:0]    frame_count,
  output logic                   drop_error,
  output logic                   drop_overflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH     = PW'(2 ** ADDR_WIDTH);
  localparam logic [PW:0]   AF_MARGIN = (PW + 1)'(ALMOST_FULL_MARGIN);

  wr_state_t wr_state_q, wr_state_d;
  logic [PW-1:0] wr_spec_q, wr_spec_d;
  logic [PW-1:0] wr_commit_q, wr_commit_d;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] frame_count_q, frame_count_d;
  logic          drop_error_q, drop_error_d;
  logic          drop_overflow_q, drop_overflow_d;
  logic          almost_full_q;
  logic          s1_valid_q;
  logic          out_valid_q;
  logic          out_last_q;
  logic [AXIS_DATA_W-1:0] out_data_q;

  logic                  wr_en;
  logic                  commit;
  logic [RAM_WORD_W-1:0] rd_word;
  logic [1:0]            in_pipe;
  logic [PW-1:0]         occupancy;
  logic [PW-1:0]         free_bytes;
  logic                  full;
  logic                  out_free;
  logic                  fetch;
  logic                  out_last_hs;

  // Bytes already fetched but not yet handed downstream still count as occupied,
  // so almost_full and full see every byte the buffer is responsible for.
  assign in_pipe    = {1'b0, s1_valid_q} + {1'b0, out_valid_q};
  assign occupancy  = wr_spec_q - rd_ptr_q + PW'(in_pipe);
  assign free_bytes = DEPTH - occupancy;
  assign full       = (occupancy == DEPTH);

  assign out_free    = !out_valid_q || m_axis_tready;
  assign fetch       = (rd_ptr_q != wr_commit_q) && (!s1_valid_q || out_free);
  assign out_last_hs = out_valid_q && m_axis_tready && out_last_q;

  always_comb begin
    wr_state_d      = wr_state_q;
    wr_spec_d       = wr_spec_q;
    wr_commit_d     = wr_commit_q;
    wr_en           = 1'b0;
    commit          = 1'b0;
    drop_error_d    = 1'b0;
    drop_overflow_d = 1'b0;
    if (s_axis_tvalid) begin
      case (wr_state_q)
        WR_ACCEPT: begin
          if (full) begin
            if (s_axis_tlast) begin
              wr_spec_d       = wr_commit_q;
              drop_overflow_d = 1'b1;
            end else begin
              wr_state_d = WR_DISCARD;
            end
          end else if (s_axis_tlast && s_axis_tuser) begin
            wr_spec_d    = wr_commit_q;
            drop_error_d = 1'b1;
          end else begin
            wr_en     = 1'b1;
            wr_spec_d = wr_spec_q + 1'b1;
            if (s_axis_tlast) begin
              wr_commit_d = wr_spec_q + 1'b1;
              commit      = 1'b1;
            end
          end
        end
        WR_DISCARD: begin
          if (s_axis_tlast) begin
            wr_spec_d       = wr_commit_q;
            drop_overflow_d = 1'b1;
            wr_state_d      = WR_ACCEPT;
          end
        end
        default: wr_state_d = WR_ACCEPT;
      endcase
    end
  end

  // A commit and a last-byte handshake in the same cycle cancel out.
  always_comb begin
    frame_count_d = frame_count_q;
    case ({commit, out_last_hs})
      2'b10:   frame_count_d = frame_count_q + 1'b1;
      2'b01:   frame_count_d = frame_count_q - 1'b1;
      default: frame_count_d = frame_count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_state_q      <= WR_ACCEPT;
      wr_spec_q       <= '0;
      wr_commit_q     <= '0;
      rd_ptr_q        <= '0;
      frame_count_q   <= '0;
      drop_error_q    <= 1'b0;
      drop_overflow_q <= 1'b0;
      almost_full_q   <= 1'b0;
      s1_valid_q      <= 1'b0;
      out_valid_q     <= 1'b0;
      out_last_q      <= 1'b0;
      out_data_q      <= '0;
    end else begin
      wr_state_q      <= wr_state_d;
      wr_spec_q       <= wr_spec_d;
      wr_commit_q     <= wr_commit_d;
      frame_count_q   <= frame_count_d;
      drop_error_q    <= drop_error_d;
      drop_overflow_q <= drop_overflow_d;
      almost_full_q   <= ({1'b0, free_bytes} < AF_MARGIN);
      if (fetch) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      s1_valid_q <= fetch || (s1_valid_q && !out_free);
      if (out_free) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_last_q <= rd_word[AXIS_DATA_W];
          out_data_q <= rd_word[AXIS_DATA_W-1:0];
        end
      end
    end
  end

  cbs_frame_buffer_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_spec_q[ADDR_WIDTH-1:0]),
    .wr_word_i ({s_axis_tlast, s_axis_tdata}),
    .rd_en_i   (fetch),
    .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_word_o (rd_word)
  );

  assign s_axis_tready = rstn;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tuser  = 1'b0;
  assign almost_full   = almost_full_q;
  assign frame_count   = frame_count_q;
  assign drop_error    = drop_error_q;
  assign drop_overflow = drop_overflow_q;

endmodule

// File: tb/tb_cbs_frame_buffer.sv
// Directed bench for cbs_frame_buffer with a 64-byte buffer and a 16-byte
// almost_full margin.
module tb_cbs_frame_buffer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] s_axis_tdata = '0;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic       s_axis_tlast = 1'b0;
  logic       s_axis_tuser = 1'b0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b0;
  logic       m_axis_tlast;
  logic       m_axis_tuser;
  logic       almost_full;
  logic [6:0] frame_count;
  logic       drop_error;
  logic       drop_overflow;

  cbs_frame_buffer #(
    .ADDR_WIDTH(6),
    .ALMOST_FULL_MARGIN(16)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .almost_full   (almost_full),
    .frame_count   (frame_count),
    .drop_error    (drop_error),
    .drop_overflow (drop_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Output monitor: a beat stamped s was handed off at the edge that makes cyc = s+1.
  logic [7:0] q_data[$];
  logic       q_last[$];
  int         q_cyc[$];
  int         first_valid_cyc = -1;
  int         n_derr = 0;
  int         n_dovf = 0;

  always @(negedge clk) begin
    if (rstn) begin
      if (m_axis_tvalid && m_axis_tready) begin
        q_data.push_back(m_axis_tdata);
        q_last.push_back(m_axis_tlast);
        q_cyc.push_back(cyc);
      end
      if (m_axis_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (drop_error) n_derr++;
      if (drop_overflow) n_dovf++;
    end
  end

  task automatic mon_clear();
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
    first_valid_cyc = -1;
    n_derr = 0;
    n_dovf = 0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tuser = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    mon_clear();
  endtask

  task automatic drive_beats(input int n, input logic [7:0] start);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = start + 8'(i);
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
    end
  endtask

  // tl_cyc is the cyc value right after the edge that accepts the tlast beat.
  task automatic send_frame(input int len, input logic [7:0] start, input logic user,
                            output int tl_cyc);
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = start + 8'(i);
      s_axis_tlast  = (i == len - 1);
      s_axis_tuser  = (i == len - 1) ? user : 1'b0;
      tl_cyc = cyc + 1;
    end
  endtask

  task automatic stop_in();
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int i = 0; i < budget && q_data.size() < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_cmp++; if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL rst_tready_low: got %0b expected 0", s_axis_tready); end
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_tvalid: got %0b expected 0", m_axis_tvalid); end
    n_cmp++; if (almost_full !== 1'b0) begin n_bad++; $display("FAIL rst_almost_full: got %0b expected 0", almost_full); end
    n_cmp++; if (frame_count !== 7'd0) begin n_bad++; $display("FAIL rst_frame_count: got %0d expected 0", frame_count); end
    n_cmp++; if ({drop_error, drop_overflow} !== 2'b00) begin n_bad++; $display("FAIL rst_pulses: got %b expected 00", {drop_error, drop_overflow}); end
    n_cmp++; if (m_axis_tuser !== 1'b0) begin n_bad++; $display("FAIL rst_tuser: got %0b expected 0", m_axis_tuser); end
    rstn = 1'b1;
    mon_clear();
    @(posedge clk); #1;
    n_cmp++; if (s_axis_tready !== 1'b1) begin n_bad++; $display("FAIL rst_tready_high: got %0b expected 1", s_axis_tready); end
  endtask

  task automatic test_single_frame();
    int tl;
    apply_reset();
    m_axis_tready = 1'b1;
    send_frame(10, 8'h01, 1'b0, tl);
    stop_in();
    n_cmp++; if (frame_count !== 7'd1) begin n_bad++; $display("FAIL t1_count_commit: got %0d expected 1", frame_count); end
    wait_beats(10, 60);
    n_cmp++; if (q_data.size() != 10) begin n_bad++; $display("FAIL t1_beats: got %0d expected 10", q_data.size()); end
    for (int i = 0; i < 10 && i < q_data.size(); i++) begin
      n_cmp++; if (q_data[i] !== 8'(i + 1) || q_last[i] !== (i == 9)) begin
        n_bad++; $display("FAIL t1_beat%0d: got %h/%0b expected %h/%0b", i, q_data[i], q_last[i], 8'(i + 1), (i == 9));
      end
    end
    n_cmp++; if (first_valid_cyc != tl + 2) begin n_bad++; $display("FAIL t1_latency: got %0d expected %0d", first_valid_cyc, tl + 2); end
    if (q_cyc.size() == 10) begin
      n_cmp++; if (q_cyc[9] != tl + 11) begin n_bad++; $display("FAIL t1_rate: got %0d expected %0d", q_cyc[9], tl + 11); end
    end
    n_cmp++; if (frame_count !== 7'd0) begin n_bad++; $display("FAIL t1_count_drain: got %0d expected 0", frame_count); end
  endtask

  task automatic test_error_drop();
    int tl;
    apply_reset();
    m_axis_tready = 1'b1;
    send_frame(8, 8'hA0, 1'b1, tl);
    stop_in();
    n_cmp++; if (drop_error !== 1'b1) begin n_bad++; $display("FAIL t2_drop_error_pulse: got %0b expected 1", drop_error); end
    n_cmp++; if (frame_count !== 7'd0) begin n_bad++; $display("FAIL t2_count: got %0d expected 0", frame_count); end
    send_frame(5, 8'hB0, 1'b0, tl);
    stop_in();
    wait_beats(5, 40);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (q_data.size() != 5) begin n_bad++; $display("FAIL t2_beats: got %0d expected 5", q_data.size()); end
    for (int i = 0; i < 5 && i < q_data.size(); i++) begin
      n_cmp++; if (q_data[i] !== 8'hB0 + 8'(i) || q_last[i] !== (i == 4)) begin
        n_bad++; $display("FAIL t2_beat%0d: got %h/%0b expected %h/%0b", i, q_data[i], q_last[i], 8'hB0 + 8'(i), (i == 4));
      end
    end
    n_cmp++; if (n_derr != 1 || n_dovf != 0) begin n_bad++; $display("FAIL t2_pulse_counts: got err=%0d ovf=%0d expected 1/0", n_derr, n_dovf); end
  endtask

  task automatic test_almost_full();
    int tl;
    apply_reset();
    m_axis_tready = 1'b0;
    for (int f = 0; f < 4; f++) begin
      send_frame(12, 8'h10 * 8'(f + 1), 1'b0, tl);
      stop_in();
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (almost_full !== 1'b0) begin n_bad++; $display("FAIL t3_af_at_48: got %0b expected 0", almost_full); end
    n_cmp++; if (frame_count !== 7'd4) begin n_bad++; $display("FAIL t3_count: got %0d expected 4", frame_count); end
    n_cmp++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h10) begin n_bad++; $display("FAIL t3_head: got %0b/%h expected 1/10", m_axis_tvalid, m_axis_tdata); end
    drive_beats(1, 8'h50);
    stop_in();
    n_cmp++; if (almost_full !== 1'b0) begin n_bad++; $display("FAIL t3_af_same_cycle: got %0b expected 0", almost_full); end
    @(posedge clk); #1;
    n_cmp++; if (almost_full !== 1'b1) begin n_bad++; $display("FAIL t3_af_at_49: got %0b expected 1", almost_full); end
    n_cmp++; if (m_axis_tdata !== 8'h10 || m_axis_tlast !== 1'b0) begin n_bad++; $display("FAIL t3_hold: got %h/%0b expected 10/0", m_axis_tdata, m_axis_tlast); end
    m_axis_tready = 1'b1;
    wait_beats(48, 120);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (q_data.size() != 48) begin n_bad++; $display("FAIL t3_drain_beats: got %0d expected 48", q_data.size()); end
    if (q_data.size() == 48) begin
      n_cmp++; if (q_data[12] !== 8'h20 || q_data[47] !== 8'h4B || q_last[47] !== 1'b1) begin
        n_bad++; $display("FAIL t3_drain_order: got %h %h/%0b expected 20 4b/1", q_data[12], q_data[47], q_last[47]);
      end
    end
    n_cmp++; if (frame_count !== 7'd0 || almost_full !== 1'b0) begin n_bad++; $display("FAIL t3_after_drain: got %0d/%0b expected 0/0", frame_count, almost_full); end
  endtask

  task automatic test_overflow();
    int tl;
    apply_reset();
    m_axis_tready = 1'b0;
    send_frame(70, 8'h00, 1'b0, tl);
    stop_in();
    n_cmp++; if (drop_overflow !== 1'b1) begin n_bad++; $display("FAIL t4_ovf_pulse: got %0b expected 1", drop_overflow); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (n_dovf != 1 || n_derr != 0) begin n_bad++; $display("FAIL t4_pulse_counts: got ovf=%0d err=%0d expected 1/0", n_dovf, n_derr); end
    n_cmp++; if (almost_full !== 1'b0) begin n_bad++; $display("FAIL t4_af_cleared: got %0b expected 0", almost_full); end
    n_cmp++; if (frame_count !== 7'd0 || m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL t4_no_frame: got %0d/%0b expected 0/0", frame_count, m_axis_tvalid); end
    // A full 64-byte frame only fits if the rollback emptied the buffer.
    send_frame(64, 8'h80, 1'b0, tl);
    stop_in();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (frame_count !== 7'd1 || n_dovf != 1) begin n_bad++; $display("FAIL t4_refill: got count=%0d ovf=%0d expected 1/1", frame_count, n_dovf); end
    n_cmp++; if (almost_full !== 1'b1) begin n_bad++; $display("FAIL t4_af_full: got %0b expected 1", almost_full); end
  endtask

  task automatic test_back_to_back();
    int tla, tlb;
    apply_reset();
    m_axis_tready = 1'b1;
    send_frame(3, 8'hC0, 1'b0, tla);
    send_frame(5, 8'hD0, 1'b0, tlb);
    stop_in();
    n_cmp++; if (frame_count !== 7'd1) begin n_bad++; $display("FAIL t5_count_overlap: got %0d expected 1", frame_count); end
    n_cmp++; if (q_cyc.size() != 3 || q_cyc[2] + 1 != tlb || q_last[2] !== 1'b1) begin
      n_bad++; $display("FAIL t5_overlap_timing: got %0d beats expected 3 ending at %0d", q_cyc.size(), tlb);
    end
    wait_beats(8, 40);
    n_cmp++; if (q_data.size() != 8) begin n_bad++; $display("FAIL t5_beats: got %0d expected 8", q_data.size()); end
    if (q_data.size() == 8) begin
      n_cmp++; if (q_data[3] !== 8'hD0 || q_data[7] !== 8'hD4 || q_last[7] !== 1'b1) begin
        n_bad++; $display("FAIL t5_second_data: got %h %h/%0b expected d0 d4/1", q_data[3], q_data[7], q_last[7]);
      end
      n_cmp++; if (q_cyc[3] != tlb + 2 || q_cyc[7] != tlb + 6) begin
        n_bad++; $display("FAIL t5_second_gapless: got %0d..%0d expected %0d..%0d", q_cyc[3], q_cyc[7], tlb + 2, tlb + 6);
      end
    end
    n_cmp++; if (frame_count !== 7'd0) begin n_bad++; $display("FAIL t5_count_end: got %0d expected 0", frame_count); end
  endtask

  task automatic test_reset_mid_frame();
    int tl;
    apply_reset();
    m_axis_tready = 1'b0;
    send_frame(4, 8'h60, 1'b0, tl);
    stop_in();
    drive_beats(5, 8'h90);
    @(posedge clk); #1;
    rstn = 1'b0;
    s_axis_tvalid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (m_axis_tvalid !== 1'b0 || frame_count !== 7'd0 || almost_full !== 1'b0) begin
      n_bad++; $display("FAIL t6_after_reset: got %0b/%0d/%0b expected 0/0/0", m_axis_tvalid, frame_count, almost_full);
    end
    rstn = 1'b1;
    mon_clear();
    m_axis_tready = 1'b1;
    send_frame(4, 8'h70, 1'b0, tl);
    stop_in();
    wait_beats(4, 30);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (q_data.size() != 4) begin n_bad++; $display("FAIL t6_beats: got %0d expected 4", q_data.size()); end
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      n_cmp++; if (q_data[i] !== 8'h70 + 8'(i) || q_last[i] !== (i == 3)) begin
        n_bad++; $display("FAIL t6_beat%0d: got %h/%0b expected %h/%0b", i, q_data[i], q_last[i], 8'h70 + 8'(i), (i == 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_error_drop();
    test_almost_full();
    test_overflow();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
